// File: rtl/traffic_pkg.sv
// Shared state encoding and default phase durations for the traffic intersection.
package traffic_pkg;

   localparam logic [2:0] PH_ALL_RED_A = 3'd0;
   localparam logic [2:0] PH_MAIN_G    = 3'd1;
   localparam logic [2:0] PH_MAIN_Y    = 3'd2;
   localparam logic [2:0] PH_ALL_RED_B = 3'd3;
   localparam logic [2:0] PH_SIDE_G    = 3'd4;
   localparam logic [2:0] PH_SIDE_Y    = 3'd5;
   localparam logic [2:0] PH_PED_WALK  = 3'd6;
   localparam logic [2:0] PH_NIGHT     = 3'd7;

   typedef enum logic [2:0] {
      ALL_RED_A = PH_ALL_RED_A,
      MAIN_G    = PH_MAIN_G,
      MAIN_Y    = PH_MAIN_Y,
      ALL_RED_B = PH_ALL_RED_B,
      SIDE_G    = PH_SIDE_G,
      SIDE_Y    = PH_SIDE_Y,
      PED_WALK  = PH_PED_WALK,
      NIGHT     = PH_NIGHT
   } state_t;

   localparam int DEF_CNT_W      = 8;
   localparam int DEF_GREEN_MAIN = 5;
   localparam int DEF_GREEN_SIDE = 3;
   localparam int DEF_YELLOW     = 2;
   localparam int DEF_ALL_RED    = 1;
   localparam int DEF_WALK       = 4;
   localparam int DEF_FLASH      = 2;

endpackage

// File: rtl/traffic_timer.sv
// Loadable down-counter timing each phase; expire flags the last cycle.
module traffic_timer #(
   parameter int             CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             expire
);

   always_ff @(posedge clk) begin
      if (rst)
         value <= RST_VAL;
      else if (load)
         value <= load_val;
      else
         value <= value - CNT_W'(1);
   end

   assign expire = (value == '0);

endmodule

// File: rtl/traffic_intersection.sv
// Intersection controller; define TRAFFIC_PED_EN for the pedestrian walk phase.
module traffic_intersection
   import traffic_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int GREEN_MAIN = DEF_GREEN_MAIN,
   parameter int GREEN_SIDE = DEF_GREEN_SIDE,
   parameter int YELLOW     = DEF_YELLOW,
   parameter int ALL_RED    = DEF_ALL_RED,
   parameter int WALK       = DEF_WALK,
   parameter int FLASH      = DEF_FLASH
) (
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_ped_req,
   input  logic       i_night,
   output logic       o_main_r,
   output logic       o_main_y,
   output logic       o_main_g,
   output logic       o_side_r,
   output logic       o_side_y,
   output logic       o_side_g,
   output logic       o_walk,
   output logic [2:0] o_phase
);

   state_t           state, nxt;
   logic             flash, flash_nxt;
   logic             expire;
   logic [CNT_W-1:0] cnt, load_val;

   function automatic logic [CNT_W-1:0] load_of(input state_t s);
      case (s)
         MAIN_G:   load_of = CNT_W'(GREEN_MAIN - 1);
         SIDE_G:   load_of = CNT_W'(GREEN_SIDE - 1);
         MAIN_Y,
         SIDE_Y:   load_of = CNT_W'(YELLOW - 1);
         PED_WALK: load_of = CNT_W'(WALK - 1);
         NIGHT:    load_of = CNT_W'(FLASH - 1);
         default:  load_of = CNT_W'(ALL_RED - 1);
      endcase
   endfunction

`ifdef TRAFFIC_PED_EN
   logic ped_pending;
`else
   logic unused_ped;
   assign unused_ped = i_ped_req;
   assign o_walk     = 1'b0;
`endif

   always_comb begin
      nxt       = state;
      flash_nxt = flash;
      if (expire) begin
         case (state)
            ALL_RED_A: begin
               if (i_night) nxt = NIGHT;
`ifdef TRAFFIC_PED_EN
               else if (ped_pending) nxt = PED_WALK;
`endif
               else nxt = MAIN_G;
            end
            MAIN_G:    nxt = MAIN_Y;
            MAIN_Y:    nxt = ALL_RED_B;
            ALL_RED_B: nxt = i_night ? NIGHT : SIDE_G;
            SIDE_G:    nxt = SIDE_Y;
            SIDE_Y:    nxt = ALL_RED_A;
`ifdef TRAFFIC_PED_EN
            PED_WALK:  nxt = MAIN_G;
`endif
            NIGHT: begin
               if (i_night) flash_nxt = ~flash;
               else nxt = ALL_RED_A;
            end
            default:   nxt = ALL_RED_A;
         endcase
         // flashing always starts from the lit half
         if (nxt == NIGHT && state != NIGHT) flash_nxt = 1'b1;
      end
   end

   assign load_val = load_of(nxt);

   traffic_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (CNT_W'(ALL_RED - 1))
   ) u_timer (
      .clk      (clk),
      .rst      (i_rst),
      .load     (expire),
      .load_val (load_val),
      .value    (cnt),
      .expire   (expire)
   );

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state    <= ALL_RED_A;
         flash    <= 1'b1;
         o_phase  <= PH_ALL_RED_A;
         o_main_r <= 1'b1;
         o_main_y <= 1'b0;
         o_main_g <= 1'b0;
         o_side_r <= 1'b1;
         o_side_y <= 1'b0;
         o_side_g <= 1'b0;
      end else begin
         state    <= nxt;
         flash    <= flash_nxt;
         o_phase  <= nxt;
         o_main_r <= nxt inside {ALL_RED_A, ALL_RED_B, SIDE_G, SIDE_Y, PED_WALK};
         o_main_y <= (nxt == MAIN_Y) || (nxt == NIGHT && flash_nxt);
         o_main_g <= (nxt == MAIN_G);
         o_side_r <= (nxt inside {ALL_RED_A, ALL_RED_B, MAIN_G, MAIN_Y, PED_WALK})
                     || (nxt == NIGHT && flash_nxt);
         o_side_y <= (nxt == SIDE_Y);
         o_side_g <= (nxt == SIDE_G);
      end
   end

`ifdef TRAFFIC_PED_EN
   always_ff @(posedge clk) begin
      if (i_rst) begin
         ped_pending <= 1'b0;
         o_walk      <= 1'b0;
      end else begin
         if (nxt == PED_WALK && state != PED_WALK)
            ped_pending <= i_ped_req;
         else
            ped_pending <= ped_pending | i_ped_req;
         o_walk <= (nxt == PED_WALK);
      end
   end
`endif

endmodule

// File: tb/tb_traffic_intersection.sv
// Directed bench: default-timing controller plus an all-ones-duration instance.
module tb_traffic_intersection;
   import traffic_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, ped, night;
   logic       rst1, ped1, night1;
   logic       ped_hold;
   logic       mr, my, mg, sr, sy, sg, walk;
   logic       mr1, my1, mg1, sr1, sy1, sg1, walk1;
   logic [2:0] ph, ph1;
   int         n_vec = 0;
   int         n_bad = 0;

   traffic_intersection u_dut (
      .clk(clk), .i_rst(rst), .i_ped_req(ped), .i_night(night),
      .o_main_r(mr), .o_main_y(my), .o_main_g(mg),
      .o_side_r(sr), .o_side_y(sy), .o_side_g(sg),
      .o_walk(walk), .o_phase(ph)
   );

   traffic_intersection #(
      .CNT_W(1), .GREEN_MAIN(1), .GREEN_SIDE(1), .YELLOW(1),
      .ALL_RED(1), .WALK(1), .FLASH(1)
   ) u_dut1 (
      .clk(clk), .i_rst(rst1), .i_ped_req(ped1), .i_night(night1),
      .o_main_r(mr1), .o_main_y(my1), .o_main_g(mg1),
      .o_side_r(sr1), .o_side_y(sy1), .o_side_g(sg1),
      .o_walk(walk1), .o_phase(ph1)
   );

   task automatic chk(input string tag, input logic [9:0] got,
                      input logic [9:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // {main r,y,g, side r,y,g, walk}
   function automatic logic [6:0] lamps(input logic [2:0] p, input logic lit);
      case (p)
         PH_MAIN_G:   lamps = 7'b001_100_0;
         PH_MAIN_Y:   lamps = 7'b010_100_0;
         PH_SIDE_G:   lamps = 7'b100_001_0;
         PH_SIDE_Y:   lamps = 7'b100_010_0;
         PH_PED_WALK: lamps = 7'b100_100_1;
         PH_NIGHT:    lamps = lit ? 7'b010_100_0 : 7'b000_000_0;
         default:     lamps = 7'b100_100_0;
      endcase
   endfunction

   task automatic run(input logic sel, input string tag, input logic [2:0] p,
                      input logic lit, input int n);
      logic [9:0] got;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (sel) got = {ph1, mr1, my1, mg1, sr1, sy1, sg1, walk1};
         else     got = {ph, mr, my, mg, sr, sy, sg, walk};
         chk(tag, got, {p, lamps(p, lit)});
      end
   endtask

   task automatic period(input string tag);
      run(0, tag, PH_MAIN_G, 0, 5);
      run(0, tag, PH_MAIN_Y, 0, 2);
      run(0, tag, PH_ALL_RED_B, 0, 1);
      run(0, tag, PH_SIDE_G, 0, 3);
      run(0, tag, PH_SIDE_Y, 0, 2);
      run(0, tag, PH_ALL_RED_A, 0, 1);
   endtask

   task automatic press(input logic v);
      ped = v | ped_hold;
   endtask

   initial begin
`ifdef TRAFFIC_PED_EN
      ped_hold = 1'b0;
`else
      ped_hold = 1'b1;
`endif
      rst = 1'b1; night = 1'b0; ped = ped_hold;
      rst1 = 1'b1; night1 = 1'b0; ped1 = ped_hold;
      @(posedge clk);
      #1;
      run(0, "reset", PH_ALL_RED_A, 1, 1);
      rst = 1'b0;
      period("normal1");
      period("normal2");

`ifdef TRAFFIC_PED_EN
      run(0, "ped", PH_MAIN_G, 0, 5);
      run(0, "ped", PH_MAIN_Y, 0, 2);
      run(0, "ped", PH_ALL_RED_B, 0, 1);
      run(0, "ped", PH_SIDE_G, 0, 1);
      press(1);
      run(0, "ped", PH_SIDE_G, 0, 1);
      press(0);
      run(0, "ped", PH_SIDE_G, 0, 1);
      run(0, "ped", PH_SIDE_Y, 0, 2);
      run(0, "ped", PH_ALL_RED_A, 0, 1);
      run(0, "walk", PH_PED_WALK, 0, 4);
      period("after_walk");
`endif

      run(0, "night", PH_MAIN_G, 0, 1);
      night = 1'b1;
      run(0, "night", PH_MAIN_G, 0, 4);
      run(0, "night", PH_MAIN_Y, 0, 2);
      run(0, "night", PH_ALL_RED_B, 0, 1);
      run(0, "flash_lit", PH_NIGHT, 1, 2);
      run(0, "flash_dark", PH_NIGHT, 0, 2);
      run(0, "flash_lit", PH_NIGHT, 1, 1);
      night = 1'b0;
      run(0, "flash_lit", PH_NIGHT, 1, 1);
      run(0, "night_exit", PH_ALL_RED_A, 0, 1);
      period("post_night");

      run(0, "rst_sy", PH_MAIN_G, 0, 5);
      run(0, "rst_sy", PH_MAIN_Y, 0, 2);
      run(0, "rst_sy", PH_ALL_RED_B, 0, 1);
      run(0, "rst_sy", PH_SIDE_G, 0, 1);
      press(1);
      run(0, "rst_sy", PH_SIDE_G, 0, 1);
      press(0);
      run(0, "rst_sy", PH_SIDE_G, 0, 1);
      run(0, "rst_sy", PH_SIDE_Y, 0, 1);
      rst = 1'b1;
      run(0, "rst_sy_hit", PH_ALL_RED_A, 0, 1);
      rst = 1'b0;
      run(0, "rst_night", PH_MAIN_G, 0, 5);
      run(0, "rst_night", PH_MAIN_Y, 0, 1);
      night = 1'b1;
      run(0, "rst_night", PH_MAIN_Y, 0, 1);
      run(0, "rst_night", PH_ALL_RED_B, 0, 1);
      run(0, "rst_night", PH_NIGHT, 1, 1);
      press(1);
      run(0, "rst_night", PH_NIGHT, 1, 1);
      press(0);
      run(0, "rst_night", PH_NIGHT, 0, 1);
      rst = 1'b1;
      night = 1'b0;
      run(0, "rst_night_hit", PH_ALL_RED_A, 0, 1);
      rst = 1'b0;
      period("post_rst");

      run(1, "u1_reset", PH_ALL_RED_A, 0, 1);
      rst1 = 1'b0;
      run(1, "u1", PH_MAIN_G, 0, 1);
      run(1, "u1", PH_MAIN_Y, 0, 1);
      run(1, "u1", PH_ALL_RED_B, 0, 1);
      run(1, "u1", PH_SIDE_G, 0, 1);
      ped1 = 1'b1;
      run(1, "u1", PH_SIDE_Y, 0, 1);
      ped1 = ped_hold;
      run(1, "u1", PH_ALL_RED_A, 0, 1);
`ifdef TRAFFIC_PED_EN
      run(1, "u1_walk", PH_PED_WALK, 0, 1);
`endif
      run(1, "u1", PH_MAIN_G, 0, 1);
      run(1, "u1", PH_MAIN_Y, 0, 1);
      run(1, "u1", PH_ALL_RED_B, 0, 1);
      run(1, "u1", PH_SIDE_G, 0, 1);
      run(1, "u1", PH_SIDE_Y, 0, 1);
      run(1, "u1", PH_ALL_RED_A, 0, 1);
      night1 = 1'b1;
      run(1, "u1_night", PH_NIGHT, 1, 1);
      run(1, "u1_night", PH_NIGHT, 0, 1);
      run(1, "u1_night", PH_NIGHT, 1, 1);
      night1 = 1'b0;
      run(1, "u1_exit", PH_ALL_RED_A, 0, 1);
      run(1, "u1_exit", PH_MAIN_G, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/traffic_intersection.md
TRAFFIC_INTERSECTION -- requirements
Module: traffic_intersection

Interface
REQ-001 Parameter CNT_W, 8, width of the phase-duration down-counter; all durations SHALL be in 1..2^CNT_W-1.
REQ-002 Parameter GREEN_MAIN, 5, main-road green duration in clk cycles.
REQ-003 Parameter GREEN_SIDE, 3, side-road green duration in clk cycles.
REQ-004 Parameter YELLOW, 2, yellow duration in clk cycles, both roads.
REQ-005 Parameter ALL_RED, 1, all-red clearance duration in clk cycles.
REQ-006 Parameter WALK, 4, pedestrian walk duration in clk cycles.
REQ-007 Parameter FLASH, 2, half-period in clk cycles of night-mode flashing.
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 i_rst  input  1  synchronous, active-high reset.
REQ-010 i_ped_req  input  1  pedestrian button, level or pulse, sampled every clk.
REQ-011 i_night  input  1  night-mode request level.
REQ-012 o_main_r / o_main_y / o_main_g  output  1 each  main-road lamps, registered.
REQ-013 o_side_r / o_side_y / o_side_g  output  1 each  side-road lamps, registered.
REQ-014 o_walk  output  1  pedestrian walk lamp, registered.
REQ-015 o_phase  output  3  current state encoding, for debug and bench checks.

Function
REQ-016 States SHALL be: ALL_RED_A, MAIN_G, MAIN_Y, ALL_RED_B, SIDE_G, SIDE_Y, PED_WALK, NIGHT.
REQ-017 Each timed state SHALL last exactly its parameter in cycles: counter loads duration-1 on entry, state advances in the cycle the counter reads 0.
REQ-018 Normal cycle SHALL be: ALL_RED_A -> MAIN_G -> MAIN_Y -> ALL_RED_B -> SIDE_G -> SIDE_Y -> ALL_RED_A.
REQ-019 Lamps: MAIN_G main green/side red; MAIN_Y main yellow/side red; SIDE_G side green/main red; SIDE_Y side yellow/main red; ALL_RED_x and PED_WALK both red.
REQ-020 Exactly one lamp per road SHALL be lit in every non-NIGHT cycle; green on both roads SHALL never occur.
REQ-021 A registered sticky flag ped_pending SHALL set on any cycle with i_ped_req=1.
REQ-022 On ALL_RED_A expiry with ped_pending=1 the FSM SHALL enter PED_WALK (o_walk=1, WALK cycles) and then MAIN_G; otherwise it enters MAIN_G directly.
REQ-023 ped_pending SHALL clear on PED_WALK entry, except that i_ped_req=1 in the entry cycle or during PED_WALK keeps/sets it for the next opportunity.
REQ-024 i_night SHALL be acted on only at ALL_RED_A or ALL_RED_B expiry; if high, the FSM enters NIGHT, with priority over PED_WALK and over the normal successor.
REQ-025 In NIGHT: main red/green off, side yellow/green off; o_main_y and o_side_r toggle together every FLASH cycles, both starting lit on entry; o_walk=0.
REQ-026 NIGHT SHALL be left at the first flash half-period boundary with i_night=0, into ALL_RED_A (full ALL_RED duration), ped_pending preserved.
REQ-027 Durations of 1 SHALL yield single-cycle states with no skipped or repeated cycles.

Reset
REQ-028 i_rst=1 SHALL force state ALL_RED_A, counter ALL_RED-1, ped_pending=0, flash phase=lit, at the next clk edge.
REQ-029 During and one cycle after reset, both roads SHALL show red only, o_walk=0, o_phase=ALL_RED_A.
REQ-030 Reset asserted mid-state (including NIGHT, PED_WALK) SHALL abandon that state with no yellow completion.

Configuration
REQ-031 Macro TRAFFIC_PED_EN defined: ped_pending, PED_WALK and o_walk behave as specified.
REQ-032 Macro TRAFFIC_PED_EN undefined: no PED_WALK state or flag logic, i_ped_req ignored, o_walk tied 0; all other timing identical.

Structure
REQ-033 Package traffic_pkg SHALL hold the state enum, o_phase encodings and default duration constants.
REQ-034 Sub-module traffic_timer SHALL implement the loadable CNT_W-bit down-counter with load, value and expire outputs.

Verification (defaults, TRAFFIC_PED_EN defined)
REQ-035 Release reset, no requests, 28 cycles -> per 14-cycle period: 5 main green, 2 main yellow, 3 side green, 2 side yellow, 2 all-red cycles.
REQ-036 1-cycle i_ped_req pulse during SIDE_G -> after ALL_RED_A, o_walk=1 for exactly 4 cycles, both red, then MAIN_G; second period has no walk.
REQ-037 i_night=1 raised during MAIN_G -> NIGHT entered at ALL_RED_B expiry; o_main_y/o_side_r toggle every 2 cycles; drop i_night -> ALL_RED_A 1 cycle -> MAIN_G.
REQ-038 i_rst pulsed in SIDE_Y and in NIGHT -> next cycle all red, o_phase=ALL_RED_A, pending request lost.
REQ-039 All parameters=1 -> each state one cycle, lamp mutual exclusion holds every cycle.
REQ-040 Build without TRAFFIC_PED_EN, hold i_ped_req=1 -> o_walk always 0, cycle identical to REQ-035.
